// File: rtl/ps2_scancode_decoder.sv
// rtl/ps2_scancode_decoder.sv - PS/2 Set-2 scan-code sequence decoder with arrow-driven position counter
//
// Assembles received bytes (E0 / F0 prefixed sequences) into single key
// events, tracks the held state of the up/down arrow keys and steps a
// saturating position counter on extended arrow make codes.
//
// Ports:
//   CLK50           in   system clock, rising edge
//   reset           in   synchronous active-high reset
//   byte_valid      in   one-cycle strobe, byte_in valid
//   byte_in[7:0]    in   received byte
//   parity_err      in   qualifies byte_valid: byte failed parity/framing
//   key_valid       out  one-cycle strobe, completed key event
//   key_code[7:0]   out  final code byte of the last event
//   key_ext         out  last event was E0-prefixed
//   key_break       out  last event was a release (F0)
//   arrow_up_held   out  extended 75 currently pressed
//   arrow_down_held out  extended 72 currently pressed
//   pos[6:0]        out  saturating position counter, 0..POS_MAX
//   seq_error       out  one-cycle strobe, byte discarded or sequence aborted

module ps2_scancode_decoder #(
    parameter logic [15:0] TIMEOUT  = 16'd50000,
    parameter logic [6:0]  POS_MAX  = 7'd99,
    parameter logic [6:0]  POS_INIT = 7'd0
) (
    input  logic       CLK50,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_in,
    input  logic       parity_err,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       arrow_up_held,
    output logic       arrow_down_held,
    output logic [6:0] pos,
    output logic       seq_error
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        key_valid_q, key_valid_d;
    logic [7:0]  key_code_q, key_code_d;
    logic        key_ext_q, key_ext_d;
    logic        key_break_q, key_break_d;
    logic        up_q, up_d;
    logic        down_q, down_d;
    logic [6:0]  pos_q, pos_d;
    logic        seq_error_q, seq_error_d;

    // Event request raised by the FSM decode, applied to the outputs below
    logic        ev;
    logic        ev_ext;
    logic        ev_brk;

    always_ff @(posedge CLK50) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 16'd0;
            key_valid_q <= 1'b0;
            key_code_q  <= 8'h00;
            key_ext_q   <= 1'b0;
            key_break_q <= 1'b0;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
            pos_q       <= POS_INIT;
            seq_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_ext_q   <= key_ext_d;
            key_break_q <= key_break_d;
            up_q        <= up_d;
            down_q      <= down_d;
            pos_q       <= pos_d;
            seq_error_q <= seq_error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        key_ext_d   = key_ext_q;
        key_break_d = key_break_q;
        up_d        = up_q;
        down_d      = down_q;
        pos_d       = pos_q;
        seq_error_d = 1'b0;
        ev          = 1'b0;
        ev_ext      = 1'b0;
        ev_brk      = 1'b0;

        if (byte_valid) begin
            // Any byte restarts the prefix timeout, even a bad one
            cnt_d = 16'd0;
            if (parity_err) begin
                seq_error_d = 1'b1;
                state_d     = S_IDLE;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (byte_in == 8'hE0) begin
                            state_d = S_EXT;
                        end else if (byte_in == 8'hF0) begin
                            state_d = S_BRK;
                        end else if (byte_in == 8'hAA || byte_in == 8'hFA ||
                                     byte_in == 8'hFC || byte_in == 8'hFE) begin
                            // Keyboard status/ack bytes: not key events
                            state_d = S_IDLE;
                        end else if (byte_in == 8'h00 || byte_in == 8'hFF) begin
                            seq_error_d = 1'b1;
                        end else begin
                            ev = 1'b1;
                        end
                    end
                    S_EXT: begin
                        if (byte_in == 8'hF0) begin
                            state_d = S_EXT_BRK;
                        end else if (byte_in == 8'hE0) begin
                            // Repeated E0 is tolerated
                            state_d = S_EXT;
                        end else if (byte_in == 8'h00 || byte_in == 8'hFF) begin
                            seq_error_d = 1'b1;
                            state_d     = S_IDLE;
                        end else begin
                            ev      = 1'b1;
                            ev_ext  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                    S_BRK, S_EXT_BRK: begin
                        state_d = S_IDLE;
                        if (byte_in == 8'hE0 || byte_in == 8'hF0) begin
                            seq_error_d = 1'b1;
                        end else begin
                            ev     = 1'b1;
                            ev_brk = 1'b1;
                            ev_ext = (state_q == S_EXT_BRK);
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end else if (state_q != S_IDLE) begin
            // Abandon a dangling prefix; a byte in this cycle takes the branch above
            if (cnt_q == TIMEOUT - 16'd1) begin
                state_d     = S_IDLE;
                seq_error_d = 1'b1;
                cnt_d       = 16'd0;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end else begin
            cnt_d = 16'd0;
        end

        if (ev) begin
            key_valid_d = 1'b1;
            key_code_d  = byte_in;
            key_ext_d   = ev_ext;
            key_break_d = ev_brk;
            // Only extended arrows count; keypad 8/2 share the codes without E0
            if (ev_ext && byte_in == 8'h75) begin
                up_d = !ev_brk;
                if (!ev_brk && pos_q < POS_MAX) begin
                    pos_d = pos_q + 7'd1;
                end
            end
            if (ev_ext && byte_in == 8'h72) begin
                down_d = !ev_brk;
                if (!ev_brk && pos_q != 7'd0) begin
                    pos_d = pos_q - 7'd1;
                end
            end
        end
    end

    assign key_valid       = key_valid_q;
    assign key_code        = key_code_q;
    assign key_ext         = key_ext_q;
    assign key_break       = key_break_q;
    assign arrow_up_held   = up_q;
    assign arrow_down_held = down_q;
    assign pos             = pos_q;
    assign seq_error       = seq_error_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb/tb_ps2_scancode_decoder.sv - self-checking bench for ps2_scancode_decoder

module tb_ps2_scancode_decoder;

    localparam logic [15:0] TB_TIMEOUT  = 16'd8;
    localparam int          TB_POS_MAX  = 3;
    localparam int          TB_POS_INIT = 1;

    logic       CLK50;
    logic       reset;
    logic       byte_valid;
    logic [7:0] byte_in;
    logic       parity_err;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       arrow_up_held;
    logic       arrow_down_held;
    logic [6:0] pos;
    logic       seq_error;

    int checks = 0;
    int errors = 0;

    // Reference model state: pending prefixes as flags, plus expected outputs
    bit       m_e0, m_f0;
    bit [7:0] m_code;
    bit       m_ext, m_brk, m_up, m_down;
    int       m_pos;
    bit       exp_kv, exp_err;

    ps2_scancode_decoder #(
        .TIMEOUT (TB_TIMEOUT),
        .POS_MAX (7'(TB_POS_MAX)),
        .POS_INIT(7'(TB_POS_INIT))
    ) dut (
        .CLK50          (CLK50),
        .reset          (reset),
        .byte_valid     (byte_valid),
        .byte_in        (byte_in),
        .parity_err     (parity_err),
        .key_valid      (key_valid),
        .key_code       (key_code),
        .key_ext        (key_ext),
        .key_break      (key_break),
        .arrow_up_held  (arrow_up_held),
        .arrow_down_held(arrow_down_held),
        .pos            (pos),
        .seq_error      (seq_error)
    );

    initial CLK50 = 1'b0;
    always #5 CLK50 = ~CLK50;

    task automatic model_reset();
        m_e0 = 0; m_f0 = 0; m_code = 8'h00; m_ext = 0; m_brk = 0;
        m_up = 0; m_down = 0; m_pos = TB_POS_INIT; exp_kv = 0; exp_err = 0;
    endtask

    task automatic model_event(input bit [7:0] b, input bit ext, input bit brk);
        exp_kv = 1; m_code = b; m_ext = ext; m_brk = brk; m_e0 = 0; m_f0 = 0;
        if (ext && b == 8'h75) begin
            m_up = !brk;
            if (!brk) m_pos = (m_pos + 1 > TB_POS_MAX) ? TB_POS_MAX : m_pos + 1;
        end
        if (ext && b == 8'h72) begin
            m_down = !brk;
            if (!brk) m_pos = (m_pos - 1 < 0) ? 0 : m_pos - 1;
        end
    endtask

    task automatic model_byte(input bit [7:0] b, input bit perr);
        exp_kv = 0; exp_err = 0;
        if (perr) begin
            exp_err = 1; m_e0 = 0; m_f0 = 0;
        end else if (m_f0) begin
            if (b == 8'hE0 || b == 8'hF0) begin exp_err = 1; m_e0 = 0; m_f0 = 0; end
            else model_event(b, m_e0, 1);
        end else if (m_e0) begin
            if (b == 8'hF0) m_f0 = 1;
            else if (b == 8'hE0) m_e0 = 1;
            else if (b == 8'h00 || b == 8'hFF) begin exp_err = 1; m_e0 = 0; end
            else model_event(b, 1, 0);
        end else begin
            if (b == 8'hE0) m_e0 = 1;
            else if (b == 8'hF0) m_f0 = 1;
            else if (b == 8'hAA || b == 8'hFA || b == 8'hFC || b == 8'hFE) exp_kv = 0;
            else if (b == 8'h00 || b == 8'hFF) exp_err = 1;
            else model_event(b, 0, 0);
        end
    endtask

    // Drive one byte for one cycle; returns at the negedge of the following cycle
    task automatic send(input logic [7:0] b, input logic perr);
        @(negedge CLK50);
        byte_valid = 1'b1; byte_in = b; parity_err = perr;
        @(negedge CLK50);
        byte_valid = 1'b0; parity_err = 1'b0; byte_in = 8'($urandom);
        model_byte(b, perr);
    endtask

    task automatic do_reset();
        @(negedge CLK50);
        reset = 1'b1;
        @(negedge CLK50);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_kv got %b exp 0", key_valid); end
        checks++; if (key_code !== 8'h00) begin errors++; $display("FAIL reset_code got %h exp 00", key_code); end
        checks++; if ({key_ext, key_break} !== 2'b00) begin errors++; $display("FAIL reset_ext_brk got %b exp 00", {key_ext, key_break}); end
        checks++; if ({arrow_up_held, arrow_down_held} !== 2'b00) begin errors++; $display("FAIL reset_held got %b exp 00", {arrow_up_held, arrow_down_held}); end
        checks++; if (pos !== 7'(TB_POS_INIT)) begin errors++; $display("FAIL reset_pos got %0d exp %0d", pos, TB_POS_INIT); end
        checks++; if (seq_error !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", seq_error); end
    endtask

    task automatic test_make_break();
        int pulses = 0;
        send(8'h1C, 0);
        pulses += int'(key_valid);
        checks++; if ({key_valid, key_code, key_ext, key_break} !== {1'b1, 8'h1C, 2'b00})
            begin errors++; $display("FAIL mb_make got kv=%b code=%h ext=%b brk=%b exp 1/1C/0/0", key_valid, key_code, key_ext, key_break); end
        @(negedge CLK50);
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL mb_pulse_width got %b exp 0", key_valid); end
        send(8'hF0, 0);
        pulses += int'(key_valid);
        send(8'h1C, 0);
        pulses += int'(key_valid);
        checks++; if ({key_valid, key_code, key_ext, key_break} !== {1'b1, 8'h1C, 2'b01})
            begin errors++; $display("FAIL mb_break got kv=%b code=%h ext=%b brk=%b exp 1/1C/0/1", key_valid, key_code, key_ext, key_break); end
        checks++; if (pulses != 2) begin errors++; $display("FAIL mb_pulse_count got %0d exp 2", pulses); end
    endtask

    task automatic test_arrow_up_saturate();
        int exp_pos[5] = '{1, 2, 3, 3, 3};
        // Walk pos from its init value down to 0 and release the down arrow
        while (m_pos > 0) begin send(8'hE0, 0); send(8'h72, 0); end
        send(8'hE0, 0); send(8'hF0, 0); send(8'h72, 0);
        for (int i = 0; i < 5; i++) begin
            send(8'hE0, 0); send(8'h75, 0);
            checks++; if (pos !== 7'(exp_pos[i]) || arrow_up_held !== 1'b1 || key_ext !== 1'b1)
                begin errors++; $display("FAIL up_step%0d got pos=%0d up=%b ext=%b exp %0d/1/1", i, pos, arrow_up_held, key_ext, exp_pos[i]); end
        end
        send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 0);
        checks++; if ({key_valid, key_ext, key_break, arrow_up_held} !== 4'b1110 || pos !== 7'd3)
            begin errors++; $display("FAIL up_break got kv=%b ext=%b brk=%b up=%b pos=%0d exp 1/1/1/0/3", key_valid, key_ext, key_break, arrow_up_held, pos); end
    endtask

    task automatic test_arrow_down_floor();
        while (m_pos > 0) begin send(8'hE0, 0); send(8'h72, 0); end
        send(8'hE0, 0); send(8'h72, 0);
        checks++; if (pos !== 7'd0 || arrow_down_held !== 1'b1)
            begin errors++; $display("FAIL down_floor got pos=%0d down=%b exp 0/1", pos, arrow_down_held); end
        send(8'h72, 0);
        checks++; if ({key_valid, key_code, key_ext} !== {1'b1, 8'h72, 1'b0} || pos !== 7'd0 || arrow_down_held !== 1'b1)
            begin errors++; $display("FAIL down_keypad got kv=%b code=%h ext=%b pos=%0d down=%b exp 1/72/0/0/1", key_valid, key_code, key_ext, pos, arrow_down_held); end
    endtask

    task automatic test_parity();
        int p0 = m_pos;
        send(8'hE0, 0);
        send(8'hF0, 1);
        checks++; if (seq_error !== 1'b1 || key_valid !== 1'b0)
            begin errors++; $display("FAIL parity_err got err=%b kv=%b exp 1/0", seq_error, key_valid); end
        send(8'h75, 0);
        checks++; if ({key_valid, key_code, key_ext, key_break} !== {1'b1, 8'h75, 2'b00} || pos !== 7'(p0))
            begin errors++; $display("FAIL parity_next got kv=%b code=%h ext=%b brk=%b pos=%0d exp 1/75/0/0/%0d", key_valid, key_code, key_ext, key_break, pos, p0); end
    endtask

    task automatic test_timeout();
        int pulses = 0;
        int at = -1;
        send(8'hE0, 0);
        for (int i = 1; i <= 12; i++) begin
            @(negedge CLK50);
            if (seq_error === 1'b1) begin pulses++; at = i; end
        end
        m_e0 = 0;
        checks++; if (pulses != 1 || at != int'(TB_TIMEOUT))
            begin errors++; $display("FAIL timeout_pulse got count=%0d at=%0d exp 1 at %0d", pulses, at, TB_TIMEOUT); end
        send(8'h1C, 0);
        checks++; if ({key_valid, key_ext} !== 2'b10)
            begin errors++; $display("FAIL timeout_idle got kv=%b ext=%b exp 1/0", key_valid, key_ext); end
        // Byte lands on the expiry cycle and must win
        send(8'hE0, 0);
        repeat (int'(TB_TIMEOUT) - 2) @(negedge CLK50);
        send(8'h75, 0);
        checks++; if (seq_error !== 1'b0 || {key_valid, key_code, key_ext} !== {1'b1, 8'h75, 1'b1} || pos !== 7'(m_pos))
            begin errors++; $display("FAIL timeout_race got err=%b kv=%b code=%h ext=%b pos=%0d exp 0/1/75/1/%0d", seq_error, key_valid, key_code, key_ext, pos, m_pos); end
        @(negedge CLK50);
        checks++; if (seq_error !== 1'b0) begin errors++; $display("FAIL timeout_race_late got %b exp 0", seq_error); end
    endtask

    task automatic test_reset_mid();
        send(8'hE0, 0); send(8'hF0, 0);
        do_reset();
        checks++; if ({key_valid, key_code, key_ext, key_break, arrow_up_held, arrow_down_held, seq_error} !== 14'd0 || pos !== 7'(TB_POS_INIT))
            begin errors++; $display("FAIL rstmid_state got code=%h pos=%0d up=%b dn=%b exp 00/%0d/0/0", key_code, pos, arrow_up_held, arrow_down_held, TB_POS_INIT); end
        send(8'h75, 0);
        checks++; if ({key_valid, key_code, key_ext, key_break} !== {1'b1, 8'h75, 2'b00})
            begin errors++; $display("FAIL rstmid_event got kv=%b code=%h ext=%b brk=%b exp 1/75/0/0", key_valid, key_code, key_ext, key_break); end
    endtask

    task automatic test_random();
        bit [7:0] pool[9] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h1C, 8'hAA, 8'h00, 8'hFF, 8'h5A};
        for (int n = 0; n < 300; n++) begin
            bit [7:0] b;
            bit perr;
            b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 8)];
            perr = ($urandom_range(0, 15) == 0);
            repeat ($urandom_range(0, 3)) @(negedge CLK50);
            send(b, perr);
            checks++; if (key_valid !== exp_kv || seq_error !== exp_err)
                begin errors++; $display("FAIL rand%0d strobes byte=%h perr=%b got kv=%b err=%b exp %b/%b", n, b, perr, key_valid, seq_error, exp_kv, exp_err); end
            checks++; if ({key_code, key_ext, key_break} !== {m_code, m_ext, m_brk})
                begin errors++; $display("FAIL rand%0d event got %h/%b/%b exp %h/%b/%b", n, key_code, key_ext, key_break, m_code, m_ext, m_brk); end
            checks++; if (pos !== 7'(m_pos) || {arrow_up_held, arrow_down_held} !== {m_up, m_down})
                begin errors++; $display("FAIL rand%0d arrows got pos=%0d up=%b dn=%b exp %0d/%b/%b", n, pos, arrow_up_held, arrow_down_held, m_pos, m_up, m_down); end
        end
    endtask

    initial begin
        reset = 1'b1; byte_valid = 1'b0; byte_in = 8'h00; parity_err = 1'b0;
        model_reset();
        repeat (2) @(negedge CLK50);
        test_reset();
        test_make_break();
        test_arrow_up_saturate();
        test_arrow_down_floor();
        test_parity();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Sits directly downstream of the PS/2 serial receiver and consumes its stream of received bytes.
- Assembles Set-2 scan-code sequences into single key events: make or break, normal or extended (E0).
- Tracks the held state of the up and down arrow keys.
- Maintains a saturating 7-bit position counter that is stepped by arrow make codes and drives the LED display.

Parameters:
- TIMEOUT, 16'd50000, CLK50 cycles allowed between a prefix byte (E0/F0) and the next byte before the sequence is abandoned.
- POS_MAX, 7'd99, upper saturation value of the position counter.
- POS_INIT, 7'd0, value loaded into the position counter on reset.

Ports:
- CLK50  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- byte_valid  input  1  one-cycle strobe; byte_in is valid in that cycle.
- byte_in  input  8  received byte.
- parity_err  input  1  qualifies byte_valid; 1 = the byte failed parity or framing.
- key_valid  output  1  one-cycle strobe marking a completed key event.
- key_code  output  8  final code byte of the event; held until the next event.
- key_ext  output  1  event was E0-prefixed; held with key_code.
- key_break  output  1  event was a release (F0); held with key_code.
- arrow_up_held  output  1  up arrow (E0 75) is currently pressed.
- arrow_down_held  output  1  down arrow (E0 72) is currently pressed.
- pos  output  7  position counter, range 0..POS_MAX.
- seq_error  output  1  one-cycle strobe: byte discarded or sequence aborted.

Behaviour:
- Reset values, all applied on the clock edge where reset=1:
  - key_valid=0, key_code=8'h00, key_ext=0, key_break=0.
  - arrow_up_held=0, arrow_down_held=0, pos=POS_INIT, seq_error=0.
  - FSM=IDLE, timeout counter=0.
- Reset mid-sequence discards any pending prefix; it has priority over every other input.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
- FSM transitions, evaluated only when byte_valid=1 and parity_err=0:
  - IDLE: E0 -> EXT; F0 -> BRK; AA/FA/FC/FE ignored, stay in IDLE, no event; 00/FF -> seq_error, stay in IDLE; any other byte -> make event, ext=0.
  - EXT: F0 -> EXT_BRK; E0 -> stay in EXT, no error; 00/FF -> seq_error, go to IDLE; any other byte -> make event, ext=1, go to IDLE.
  - BRK: E0 or F0 -> seq_error, go to IDLE; any other byte -> break event, ext=0, go to IDLE.
  - EXT_BRK: E0 or F0 -> seq_error, go to IDLE; any other byte -> break event, ext=1, go to IDLE.
- Parity errors:
  - byte_valid=1 with parity_err=1 -> byte discarded, seq_error=1, FSM returns to IDLE from any state.
  - byte_in is ignored in that cycle.
- Event output and latency:
  - key_valid pulses in the cycle after the byte_valid of the final byte.
  - key_code, key_ext and key_break update in that same cycle and hold until the next event.
- Timeout:
  - The counter runs only while in EXT, BRK or EXT_BRK, and clears on every byte_valid and on entry to IDLE.
  - When the counter reaches TIMEOUT-1 with no byte_valid in that cycle, the FSM goes to IDLE and seq_error pulses one cycle.
  - A byte_valid in the expiry cycle wins: that byte is processed and no timeout occurs.
- Arrow tracking, on ext=1 events only:
  - make 75 sets arrow_up_held; break 75 clears it.
  - make 72 sets arrow_down_held; break 72 clears it.
  - Non-extended 75/72 (keypad 8/2) do not affect the held flags or pos.
- Position counter:
  - Each ext make 75, including typematic repeats without an intervening break, increments pos.
  - Each ext make 72 decrements pos.
  - pos saturates at POS_MAX and at 0; there is no wrap.
  - pos updates in the same cycle as key_valid.
  - Break events never change pos.
- Widths: byte compares are full 8-bit; pos arithmetic is 7-bit unsigned with saturation checked before the update.
- byte_valid is a clean single-cycle strobe, already synchronous to CLK50; this block performs no synchronisation.

Test Plan:
- Plain make/break: bytes 1C, F0, 1C -> event 1 {code=1C, ext=0, brk=0}, event 2 {code=1C, ext=0, brk=1}; key_valid pulses exactly twice, each one cycle after its final byte.
- Arrow up with saturation: POS_MAX=3, then E0 75 repeated 5 times, then E0 F0 75:
  - pos steps 1, 2, 3, 3, 3.
  - arrow_up_held=1 from the first event.
  - After the break: arrow_up_held=0, pos stays 3, the break event has ext=1, brk=1.
- Arrow down at floor and keypad code: pos=0, then E0 72 -> pos stays 0, arrow_down_held=1; then 72 alone -> event {code=72, ext=0}, pos unchanged, held flag unchanged.
- Parity error mid-sequence: E0, then F0 with parity_err=1 -> seq_error pulse, FSM in IDLE; a following 75 gives a make event {code=75, ext=0} and pos is unchanged.
- Timeout and simultaneous byte, with TIMEOUT=8:
  - After E0, idle 8 cycles -> seq_error pulses once, IDLE.
  - Repeat with 75 arriving on the expiry cycle -> no seq_error, ext make 75, pos+1.
- Reset mid-sequence: E0 F0, then reset=1 for one cycle, then 75 -> all outputs at reset values, pos=POS_INIT, then a make event with ext=0, brk=0.
